// File: rtl/ahb_mem_arbiter_pkg.sv
// Shared constants and types for the two-master AHB memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    PARK = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

  function automatic logic [1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ahb_mem_arbiter_rr_arb.sv
// Two-way round-robin pick: the requester that was not served last wins a tie.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is taken.
module ahb_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_vld,
  output logic       o_idx
);

  // Single requester wins outright; a tie goes to the master other than i_last.
  always_comb begin
    o_vld = |i_req;
    o_idx = i_last;
    case (i_req)
      2'b01:   o_idx = 1'b0;
      2'b10:   o_idx = 1'b1;
      2'b11:   o_idx = ~i_last;
      default: o_idx = i_last;
    endcase
  end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter/mux in front of one memory slave.
// Latency: grant registered (one cycle); address mux combinational; hwdata mux follows the registered data-phase owner.
// Backpressure: s_hreadyout=0 freezes grant, FSM and data-phase owner; ready/resp/rdata pass straight to both masters.
module ahb_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEF_MST = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [1:0]             m_hbusreq,
  input  logic [1:0][ADDR_W-1:0] m_haddr,
  input  logic [1:0][1:0]        m_htrans,
  input  logic [1:0]             m_hwrite,
  input  logic [1:0][2:0]        m_hsize,
  input  logic [1:0][DATA_W-1:0] m_hwdata,
  output logic [1:0]             m_hgrant,
  output logic                   m_hready,
  output logic [DATA_W-1:0]      m_hrdata,
  output logic                   m_hresp,
  output logic [ADDR_W-1:0]      s_haddr,
  output logic [1:0]             s_htrans,
  output logic                   s_hwrite,
  output logic [2:0]             s_hsize,
  output logic [DATA_W-1:0]      s_hwdata,
  output logic                   s_hselx,
  output logic                   s_hready,
  input  logic                   s_hreadyout,
  input  logic [DATA_W-1:0]      s_hrdata,
  input  logic                   s_hresp
);
  import ahb_arb_pkg::*;

  localparam logic DEF_IDX = (DEF_MST != 0);

  arb_state_e r_state;
  logic [1:0] r_grant;
  logic       r_rr_last;
  logic       r_dph_owner;
  logic       r_dph_valid;

  logic w_gidx;
  logic w_own_idx;
  logic w_hold;
  logic w_arb_last;
  logic w_arb_vld;
  logic w_arb_idx;

  assign w_gidx    = r_grant[1];
  assign w_own_idx = (r_state == OWN1);

  // An owner keeps the bus while it still requests and is mid-transfer, so bursts are never split.
  assign w_hold = (r_state != PARK) && m_hbusreq[w_own_idx] && htrans_active(m_htrans[w_own_idx]);

  // From PARK ties use the stored round-robin pointer; when an owner lets go,
  // treating the owner as "last served" hands a tie to the other master.
  assign w_arb_last = (r_state == PARK) ? r_rr_last : w_own_idx;

  ahb_rr_arb u_rr_arb (
    .i_req  (m_hbusreq),
    .i_last (w_arb_last),
    .o_vld  (w_arb_vld),
    .o_idx  (w_arb_idx)
  );

  // Arbitration FSM: state, grant and round-robin pointer move only on ready cycles.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state   <= PARK;
      r_grant   <= idx2onehot(DEF_IDX);
      r_rr_last <= DEF_IDX;
    end else if (s_hreadyout && !w_hold) begin
      if (w_arb_vld) begin
        r_state <= w_arb_idx ? OWN1 : OWN0;
        r_grant <= idx2onehot(w_arb_idx);
        if ((r_state != PARK) && (w_arb_idx != w_own_idx)) begin
          r_rr_last <= w_own_idx;
        end
      end else begin
        r_state <= PARK;
        r_grant <= idx2onehot(DEF_IDX);
      end
    end
  end

  // Data-phase owner advances only when the slave completes the current phase.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_dph_owner <= DEF_IDX;
      r_dph_valid <= 1'b0;
    end else if (s_hreadyout) begin
      r_dph_owner <= w_gidx;
      r_dph_valid <= htrans_active(s_htrans);
    end
  end

  // Address phase follows the registered grant; write data follows the data-phase owner.
  always_comb begin
    s_haddr  = m_haddr[w_gidx];
    s_htrans = m_htrans[w_gidx];
    s_hwrite = m_hwrite[w_gidx];
    s_hsize  = m_hsize[w_gidx];
    s_hselx  = htrans_active(m_htrans[w_gidx]);
    s_hwdata = m_hwdata[r_dph_owner];
  end

  assign m_hgrant = r_grant;
  assign m_hready = s_hreadyout;
  assign m_hrdata = s_hrdata;
  assign m_hresp  = s_hresp;
  assign s_hready = s_hreadyout;

  a_grant_onehot : assert property (@(posedge hclk) disable iff (!hresetn) $onehot(m_hgrant));

  a_dph_owner_stable : assert property (@(posedge hclk) disable iff (!hresetn)
    (r_dph_valid && !s_hreadyout) |=> $stable(r_dph_owner));

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter with a queue-based scoreboard on address and data phases.
// Latency: stimulus is cycle-scripted; the monitor checks at each falling edge.
// Backpressure: the bench plays the slave and inserts wait and ERROR cycles.
module tb_ahb_mem_arbiter;
  import ahb_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic               hclk;
  logic               hresetn;
  logic [1:0]         m_hbusreq;
  logic [1:0][AW-1:0] m_haddr;
  logic [1:0][1:0]    m_htrans;
  logic [1:0]         m_hwrite;
  logic [1:0][2:0]    m_hsize;
  logic [1:0][DW-1:0] m_hwdata;
  logic [1:0]         m_hgrant;
  logic               m_hready;
  logic [DW-1:0]      m_hrdata;
  logic               m_hresp;
  logic [AW-1:0]      s_haddr;
  logic [1:0]         s_htrans;
  logic               s_hwrite;
  logic [2:0]         s_hsize;
  logic [DW-1:0]      s_hwdata;
  logic               s_hselx;
  logic               s_hready;
  logic               s_hreadyout;
  logic [DW-1:0]      s_hrdata;
  logic               s_hresp;

  ahb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEF_MST(0)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .m_hbusreq   (m_hbusreq),
    .m_haddr     (m_haddr),
    .m_htrans    (m_htrans),
    .m_hwrite    (m_hwrite),
    .m_hsize     (m_hsize),
    .m_hwdata    (m_hwdata),
    .m_hgrant    (m_hgrant),
    .m_hready    (m_hready),
    .m_hrdata    (m_hrdata),
    .m_hresp     (m_hresp),
    .s_haddr     (s_haddr),
    .s_htrans    (s_htrans),
    .s_hwrite    (s_hwrite),
    .s_hsize     (s_hsize),
    .s_hwdata    (s_hwdata),
    .s_hselx     (s_hselx),
    .s_hready    (s_hready),
    .s_hreadyout (s_hreadyout),
    .s_hrdata    (s_hrdata),
    .s_hresp     (s_hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic          mst;
    logic [AW-1:0] addr;
    logic          wr;
    logic [1:0]    tr;
  } a_t;

  typedef struct {
    logic          wr;
    logic [DW-1:0] dat;
    logic          resp;
  } d_t;

  a_t exp_a[$];
  d_t exp_d[$];

  int   checks = 0;
  int   errors = 0;
  logic dph_pend = 1'b0;
  logic dph_wr   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic gchk(input string nm, input logic [1:0] exp);
    chk(nm, 32'(m_hgrant), 32'(exp));
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic neg();
    @(negedge hclk);
  endtask

  task automatic mset(input int m, input logic req, input logic [1:0] tr,
                      input logic [AW-1:0] a, input logic wr);
    m_hbusreq[m] = req;
    m_htrans[m]  = tr;
    m_haddr[m]   = a;
    m_hwrite[m]  = wr;
  endtask

  task automatic pa(input logic mst, input logic [AW-1:0] a, input logic wr, input logic [1:0] tr);
    a_t e;
    e.mst = mst; e.addr = a; e.wr = wr; e.tr = tr;
    exp_a.push_back(e);
  endtask

  task automatic pd(input logic wr, input logic [DW-1:0] dat, input logic resp);
    d_t e;
    e.wr = wr; e.dat = dat; e.resp = resp;
    exp_d.push_back(e);
  endtask

  // Monitor: pops expectations whenever the slave completes an address or data phase.
  always @(negedge hclk) begin : mon
    a_t a;
    d_t d;
    if (!hresetn) begin
      dph_pend = 1'b0;
    end else if (s_hreadyout) begin
      if (dph_pend) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d_unexpected got=data_phase want=none t=%0t", $time);
        end else begin
          d = exp_d.pop_front();
          chk("d_write", 32'(dph_wr), 32'(d.wr));
          if (d.wr) chk("d_hwdata", s_hwdata, d.dat);
          else      chk("d_hrdata", m_hrdata, d.dat);
          chk("d_hresp", 32'(m_hresp), 32'(d.resp));
        end
      end
      dph_pend = s_hselx;
      dph_wr   = s_hwrite;
      if (s_hselx) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected got=addr_%h want=none t=%0t", s_haddr, $time);
        end else begin
          a = exp_a.pop_front();
          chk("a_grant", 32'(m_hgrant), 32'(idx2onehot(a.mst)));
          chk("a_haddr", 32'(s_haddr), 32'(a.addr));
          chk("a_hwrite", 32'(s_hwrite), 32'(a.wr));
          chk("a_htrans", 32'(s_htrans), 32'(a.tr));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    hresetn     = 1'b0;
    m_hbusreq   = 2'b11;
    m_htrans    = '0;
    m_haddr     = '0;
    m_hwrite    = '0;
    m_hsize     = {3'b010, 3'b010};
    m_hwdata[0] = 32'h5A5A_5A5A;
    m_hwdata[1] = 32'hA5A5_A5A5;
    s_hreadyout = 1'b1;
    s_hrdata    = 32'h0;
    s_hresp     = HRESP_OKAY;

    // Reset with both masters requesting
    for (int i = 0; i < 2; i++) begin
      step(); neg();
      gchk("rst_grant", 2'b01);
      chk("rst_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
      chk("rst_hselx", 32'(s_hselx), 32'd0);
    end
    step(); hresetn = 1'b1; m_hbusreq = 2'b00; neg();
    gchk("park_grant", 2'b01);

    // Single master m1 write
    step(); mset(1, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("single_lat", 2'b01);
    step(); mset(1, 1'b1, HTRANS_NONSEQ, 16'h0040, 1'b1); pa(1'b1, 16'h0040, 1'b1, HTRANS_NONSEQ); neg();
    gchk("single_grant", 2'b10);
    step(); mset(1, 1'b0, HTRANS_IDLE, 16'h0040, 1'b0); m_hwdata[1] = 32'hDEAD_BEEF;
    pd(1'b1, 32'hDEAD_BEEF, HRESP_OKAY); neg();
    step(); neg();
    gchk("single_park", 2'b01);

    // Contention from PARK: grants go 1, 0, 1
    step(); mset(0, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); mset(1, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("cont_c0", 2'b01);
    step(); mset(1, 1'b0, HTRANS_NONSEQ, 16'h0300, 1'b1); pa(1'b1, 16'h0300, 1'b1, HTRANS_NONSEQ); neg();
    gchk("cont_r1", 2'b10);
    step(); m_hwdata[1] = 32'h1111_0300; pd(1'b1, 32'h1111_0300, HRESP_OKAY);
    mset(1, 1'b1, HTRANS_IDLE, 16'h0, 1'b0);
    mset(0, 1'b0, HTRANS_NONSEQ, 16'h0200, 1'b1); pa(1'b0, 16'h0200, 1'b1, HTRANS_NONSEQ); neg();
    gchk("cont_r2", 2'b01);
    step(); m_hwdata[0] = 32'h2222_0200; pd(1'b1, 32'h2222_0200, HRESP_OKAY);
    mset(0, 1'b0, HTRANS_IDLE, 16'h0, 1'b0);
    mset(1, 1'b0, HTRANS_NONSEQ, 16'h0304, 1'b1); pa(1'b1, 16'h0304, 1'b1, HTRANS_NONSEQ); neg();
    gchk("cont_r3", 2'b10);
    step(); m_hwdata[1] = 32'h3333_0304; pd(1'b1, 32'h3333_0304, HRESP_OKAY);
    mset(1, 1'b0, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("cont_park", 2'b01);

    // m0 four-beat burst while m1 requests
    step(); mset(0, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    step(); mset(0, 1'b1, HTRANS_NONSEQ, 16'h0100, 1'b1); pa(1'b0, 16'h0100, 1'b1, HTRANS_NONSEQ);
    mset(1, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    for (int b = 1; b < 4; b++) begin
      step();
      mset(0, 1'b1, HTRANS_SEQ, 16'(16'h0100 + 4 * b), 1'b1);
      pa(1'b0, 16'(16'h0100 + 4 * b), 1'b1, HTRANS_SEQ);
      m_hwdata[0] = 32'hB000_0100 + 32'(4 * (b - 1));
      pd(1'b1, 32'hB000_0100 + 32'(4 * (b - 1)), HRESP_OKAY);
      neg();
      gchk("burst_hold", 2'b01);
    end
    step(); mset(0, 1'b1, HTRANS_IDLE, 16'h010C, 1'b0); m_hwdata[0] = 32'hB000_010C;
    pd(1'b1, 32'hB000_010C, HRESP_OKAY); neg();
    gchk("burst_last", 2'b01);
    step(); mset(0, 1'b0, HTRANS_IDLE, 16'h0, 1'b0);
    mset(1, 1'b0, HTRANS_NONSEQ, 16'h0400, 1'b1); pa(1'b1, 16'h0400, 1'b1, HTRANS_NONSEQ); neg();
    gchk("burst_handover", 2'b10);
    step(); m_hwdata[1] = 32'h4444_0400; pd(1'b1, 32'h4444_0400, HRESP_OKAY);
    mset(1, 1'b0, HTRANS_IDLE, 16'h0, 1'b0); neg();

    // Wait states in m0 data phase with m1 requesting
    step(); mset(0, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    step(); mset(0, 1'b1, HTRANS_NONSEQ, 16'h0500, 1'b1); pa(1'b0, 16'h0500, 1'b1, HTRANS_NONSEQ);
    mset(1, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    step(); mset(0, 1'b0, HTRANS_NONSEQ, 16'h0504, 1'b1); pa(1'b0, 16'h0504, 1'b1, HTRANS_NONSEQ);
    m_hwdata[0] = 32'h5555_0500; pd(1'b1, 32'h5555_0500, HRESP_OKAY);
    s_hreadyout = 1'b0;
    for (int w = 0; w < 3; w++) begin
      if (w > 0) step();
      neg();
      gchk("wait_grant", 2'b01);
      chk("wait_haddr", 32'(s_haddr), 32'h0504);
      chk("wait_hwdata", s_hwdata, 32'h5555_0500);
      chk("wait_hready", 32'(m_hready), 32'd0);
    end
    step(); s_hreadyout = 1'b1; neg();
    gchk("wait_release", 2'b01);
    step(); m_hwdata[0] = 32'h5555_0504; pd(1'b1, 32'h5555_0504, HRESP_OKAY);
    mset(0, 1'b0, HTRANS_IDLE, 16'h0, 1'b0);
    mset(1, 1'b0, HTRANS_NONSEQ, 16'h0600, 1'b0); pa(1'b1, 16'h0600, 1'b0, HTRANS_NONSEQ); neg();
    gchk("wait_handover", 2'b10);
    step(); s_hrdata = 32'h6666_0600; pd(1'b0, 32'h6666_0600, HRESP_OKAY);
    mset(1, 1'b0, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("wait_park", 2'b01);

    // Two-cycle ERROR to m1, then reset mid-burst
    step(); mset(1, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    step(); mset(1, 1'b1, HTRANS_NONSEQ, 16'h0700, 1'b0); pa(1'b1, 16'h0700, 1'b0, HTRANS_NONSEQ);
    mset(0, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("err_own", 2'b10);
    step(); mset(1, 1'b1, HTRANS_NONSEQ, 16'h0710, 1'b1); pa(1'b1, 16'h0710, 1'b1, HTRANS_NONSEQ);
    s_hreadyout = 1'b0; s_hresp = HRESP_ERROR; s_hrdata = 32'hBAD0_BAD0;
    pd(1'b0, 32'hBAD0_BAD0, HRESP_ERROR); neg();
    chk("err1_hresp", 32'(m_hresp), 32'd1);
    chk("err1_hready", 32'(m_hready), 32'd0);
    gchk("err1_grant", 2'b10);
    step(); s_hreadyout = 1'b1; neg();
    chk("err2_hresp", 32'(m_hresp), 32'd1);
    gchk("err2_grant", 2'b10);
    step(); s_hresp = HRESP_OKAY;
    mset(1, 1'b1, HTRANS_SEQ, 16'h0714, 1'b1); pa(1'b1, 16'h0714, 1'b1, HTRANS_SEQ);
    m_hwdata[1] = 32'h7777_0710; pd(1'b1, 32'h7777_0710, HRESP_OKAY); neg();
    gchk("burst1_hold", 2'b10);
    step(); hresetn = 1'b0; mset(1, 1'b1, HTRANS_SEQ, 16'h0718, 1'b1); m_hwdata[1] = 32'h7777_0714; neg();
    step(); hresetn = 1'b1; mset(1, 1'b0, HTRANS_IDLE, 16'h0, 1'b0); mset(0, 1'b0, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("midrst_grant", 2'b01);
    chk("midrst_hselx", 32'(s_hselx), 32'd0);
    step(); mset(0, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); mset(1, 1'b1, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("postrst_park", 2'b01);
    step(); mset(0, 1'b0, HTRANS_IDLE, 16'h0, 1'b0); mset(1, 1'b0, HTRANS_IDLE, 16'h0, 1'b0); neg();
    gchk("postrst_rr", 2'b10);
    step(); neg();
    step(); neg();
    gchk("final_park", 2'b01);

    chk("addr_left", 32'(exp_a.size()), 32'd0);
    chk("data_left", 32'(exp_d.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_mem_arbiter.md
Name: ahb_mem_arbiter

Overview:
- Two-master AHB-Lite arbiter and multiplexer in front of the single AHB memory slave.
- Grants the shared address phase to one master at a time and tracks the data-phase owner.
- Routes hwdata from the data-phase owner to the slave and broadcasts the slave response to both masters.
- Sits between the two bus masters (CPU-side, DMA-side) and the memory slave port.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 32, data width
- DEF_MST, 0, park/default master index (0 or 1)

Ports:
- hclk  input  1  bus clock
- hresetn  input  1  reset; synchronous, active-low
- m_hbusreq  input  2  bus request, bit n = master n
- m_haddr  input  2xADDR_W  per-master address
- m_htrans  input  2x2  per-master transfer type
- m_hwrite  input  2  per-master write flag
- m_hsize  input  2x3  per-master transfer size
- m_hwdata  input  2xDATA_W  per-master write data
- m_hgrant  output  2  one-hot grant
- m_hready  output  1  shared ready to both masters (= s_hreadyout)
- m_hrdata  output  DATA_W  shared read data (= s_hrdata)
- m_hresp  output  1  shared response (= s_hresp)
- s_haddr  output  ADDR_W  to slave
- s_htrans  output  2  to slave
- s_hwrite  output  1  to slave
- s_hsize  output  3  to slave
- s_hwdata  output  DATA_W  to slave
- s_hselx  output  1  slave select
- s_hready  output  1  hready to slave (= s_hreadyout)
- s_hreadyout  input  1  slave ready
- s_hrdata  input  DATA_W  slave read data
- s_hresp  input  1  slave response (0 OKAY, 1 ERROR)

Behaviour:
- Reset (hresetn=0 sampled at hclk) values:
  - state=PARK, m_hgrant=one-hot(DEF_MST), dph_owner=DEF_MST, dph_valid=0, rr_last=DEF_MST.
  - Reset taken mid-transfer aborts ownership; nothing is replayed.
- FSM states: PARK (no request, default master granted), OWN0, OWN1.
- Arbitration:
  - Grant may change only on a cycle where s_hreadyout=1.
  - The new grant is registered and takes effect on the next cycle (one-cycle grant latency).
- PARK:
  - Single requester n: go to OWNn.
  - Both requesting: go to OWN of the master != rr_last.
  - No requesters: stay in PARK.
- OWNn, with s_hreadyout=1:
  - Hold while m_hbusreq[n]=1 and m_htrans[n] is NONSEQ(2'b10) or SEQ(2'b11). A burst is never split.
  - Otherwise, if the other master requests, go to OWN(other) and set rr_last=n.
  - Otherwise, if m_hbusreq[n]=1, stay.
  - Otherwise go to PARK.
- In PARK, the granted master's m_htrans is forwarded. A parked master that did not request must drive IDLE (master's obligation).
- Address mux: s_haddr/s_htrans/s_hwrite/s_hsize = fields of the currently granted master (combinational on m_hgrant). s_hselx = s_htrans[1].
- Data phase:
  - When s_hreadyout=1: dph_owner <= granted index, dph_valid <= s_htrans[1].
  - s_hwdata = m_hwdata[dph_owner], combinational.
  - A grant change never changes dph_owner until the current data phase completes.
- Wait states (s_hreadyout=0): grant, dph_owner and all address outputs hold. Masters see m_hready=0.
- ERROR response: passed through unchanged over both cycles of the 2-cycle ERROR. The grant does not change during the first ERROR cycle, because s_hreadyout=0 in that cycle.
- Simultaneous requests in the same cycle are resolved by round-robin via rr_last. Fairness bound: a requester waits at most one burst of the other master.
- Invalid one-hot or X on m_hbusreq: the design is never allowed to produce a zero or multi-hot m_hgrant; an assertion covers this.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - arb_state_e enum {PARK, OWN0, OWN1}.
  - HRESP_OKAY/ERROR constants.
- One sub-module, ahb_rr_arb: 2-way round-robin grant logic (req, rr_last → next index).
- The top level holds the FSM, the data-phase register and the muxes.

Test Plan:
- Reset: hresetn=0 for 2 cycles, m_hbusreq=2'b11 → m_hgrant=2'b01, s_htrans=IDLE, dph_valid=0 throughout.
- Single master: m1 requests, NONSEQ write haddr=16'h0040, hwdata=32'hDEADBEEF → m_hgrant=2'b10 next cycle; slave sees addr then data from m1 one cycle later.
- Contention: both request at the same cycle from PARK (rr_last=0) → m1 granted first. After m1 releases, m0 granted. Grants alternate 1,0,1 over 3 rounds.
- Burst hold: m0 runs a 4-beat SEQ burst from 16'h0100 while m1 requests → m1 granted only after the 4th beat's address phase completes. No interleaving.
- Wait states: slave holds s_hreadyout=0 for 3 cycles during an m0 data phase, m1 requesting → m_hgrant, s_haddr and s_hwdata stable for those 3 cycles. Handover occurs only after ready returns.
- Error plus reset: slave returns 2-cycle ERROR to m1 → m_hresp=1 for 2 cycles, grant unchanged in cycle 1. Assert hresetn=0 mid-burst → next cycle m_hgrant=2'b01 and state=PARK.
